// File: rtl/multiplier.sv
// rtl/multiplier.sv - unsigned M x N multiplier, partial-product array, registered product
// Ripple-carry rows built from full adders; one product per clock, 1-cycle latency.
module multiplier #(
   parameter int M = 3,
   parameter int N = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [M-1:0]     A,
   input  logic [N-1:0]     B,
   input  logic             in_valid,
   output logic [M+N-1:0]   P,
   output logic             out_valid
);

   logic [M+N-1:0] acc [N];
   logic [M:0]     carry [N];
   logic [M+N-1:0] p_d, p_q;
   logic           out_valid_d, out_valid_q;

   // Row j adds A & B[j] at bit offset j; accumulator never exceeds M+j bits,
   // so the row's carry-out lands in the still-zero bit j+M.
   always_comb begin
      logic pp;
      logic s;
      pp = 1'b0;
      s  = 1'b0;
      for (int j = 0; j < N; j++) begin
         acc[j]   = '0;
         carry[j] = '0;
      end
      for (int i = 0; i < M; i++) begin
         acc[0][i] = A[i] & B[0];
      end
      for (int j = 1; j < N; j++) begin
         acc[j] = acc[j-1];
         for (int i = 0; i < M; i++) begin
            pp             = A[i] & B[j];
            s              = acc[j-1][i+j] ^ pp;
            acc[j][i+j]    = s ^ carry[j][i];
            carry[j][i+1]  = (acc[j-1][i+j] & pp) | (carry[j][i] & s);
         end
         acc[j][j+M] = carry[j][M];
      end
   end

   always_comb begin
      p_d         = p_q;
      out_valid_d = 1'b0;
      if (in_valid) begin
         p_d         = acc[N-1];
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         p_q         <= p_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign P         = p_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - directed and table-driven checks of multiplier at three widths
module tb_multiplier;

   logic clk;
   logic rst_n;

   logic [2:0] a0;
   logic [1:0] b0;
   logic       v0;
   logic [4:0] p0;
   logic       ov0;

   logic [7:0] a1;
   logic [0:0] b1;
   logic       v1;
   logic [8:0] p1;
   logic       ov1;

   logic [3:0] a2;
   logic [3:0] b2;
   logic       v2;
   logic [7:0] p2;
   logic       ov2;

   int n_checks = 0;
   int n_fail   = 0;

   multiplier #(.M(3), .N(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .A(a0), .B(b0), .in_valid(v0), .P(p0), .out_valid(ov0)
   );
   multiplier #(.M(8), .N(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .in_valid(v1), .P(p1), .out_valid(ov1)
   );
   multiplier #(.M(4), .N(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .in_valid(v2), .P(p2), .out_valid(ov2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] a;
      logic [1:0] b;
      logic [4:0] p;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t sweep [32];
      vec_t zeros [2];
      logic [7:0] ra;
      logic [3:0] rb;

      for (int i = 0; i < 32; i++) begin
         sweep[i].a = 3'(i >> 2);
         sweep[i].b = 2'(i & 3);
         sweep[i].p = 5'(sweep[i].a * sweep[i].b);
      end
      zeros[0] = '{a: 3'd7, b: 2'd0, p: 5'd0};
      zeros[1] = '{a: 3'd0, b: 2'd3, p: 5'd0};

      rst_n = 1'b1;
      a0 = 3'd7; b0 = 2'd3; v0 = 1'b1;
      a1 = 8'd255; b1 = 1'b1; v1 = 1'b1;
      a2 = 4'd15; b2 = 4'd15; v2 = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_p0", 32'(p0), 0);
      chk("reset_ov0", 32'(ov0), 0);
      chk("reset_p1", 32'(p1), 0);
      chk("reset_p2", 32'(p2), 0);
      step();
      step();
      chk("in_reset_ignored_p0", 32'(p0), 0);
      chk("in_reset_ignored_ov0", 32'(ov0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      v1 = 1'b0; v2 = 1'b0;

      // exhaustive back-to-back sweep
      for (int i = 0; i < 32; i++) begin
         a0 = sweep[i].a; b0 = sweep[i].b; v0 = 1'b1;
         step();
         chk($sformatf("sweep_p_%0dx%0d", sweep[i].a, sweep[i].b), 32'(p0), 32'(sweep[i].p));
         chk("sweep_ov", 32'(ov0), 1);
         if (i == 0)  chk("cp_0x0", 32'(p0), 0);
         if (i == 22) chk("cp_5x2", 32'(p0), 10);
         if (i == 31) chk("cp_7x3", 32'(p0), 21);
      end

      for (int i = 0; i < 2; i++) begin
         a0 = zeros[i].a; b0 = zeros[i].b; v0 = 1'b1;
         step();
         chk("zero_p", 32'(p0), 32'(zeros[i].p));
         chk("zero_ov", 32'(ov0), 1);
      end

      // hold: P keeps 18 while in_valid low, even with X operands
      a0 = 3'd6; b0 = 2'd3; v0 = 1'b1;
      step();
      chk("hold_capture", 32'(p0), 18);
      v0 = 1'b0; a0 = 3'd1; b0 = 2'd1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("hold_p", 32'(p0), 18);
         chk("hold_ov", 32'(ov0), 0);
      end
      a0 = 3'bx; b0 = 2'bx;
      step();
      chk("hold_x_p", 32'(p0), 18);

      // asynchronous reset between edges
      a0 = 3'd7; b0 = 2'd3; v0 = 1'b1;
      step();
      chk("pre_reset_p", 32'(p0), 21);
      chk("pre_reset_ov", 32'(ov0), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_p", 32'(p0), 0);
      chk("async_reset_ov", 32'(ov0), 0);
      #1 rst_n = 1'b1;
      a0 = 3'd4; b0 = 2'd2;
      step();
      chk("post_reset_p", 32'(p0), 8);
      chk("post_reset_ov", 32'(ov0), 1);
      v0 = 1'b0;
      step();
      chk("pulse_ov", 32'(ov0), 0);

      // wide parameter corners
      a1 = 8'd255; b1 = 1'b1; v1 = 1'b1;
      a2 = 4'd15; b2 = 4'd15; v2 = 1'b1;
      step();
      chk("m8n1_255x1", 32'(p1), 255);
      chk("m4n4_15x15", 32'(p2), 225);
      a1 = 8'd170; b1 = 1'b0;
      step();
      chk("m8n1_170x0", 32'(p1), 0);
      chk("m8n1_ov", 32'(ov1), 1);

      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 4'($urandom_range(0, 15));
         a1 = ra; b1 = rb[0];
         a2 = ra[3:0]; b2 = rb;
         step();
         chk("rand_m8n1", 32'(p1), 32'(ra) * 32'(rb[0]));
         chk("rand_m4n4", 32'(p2), 32'(ra[3:0]) * 32'(rb));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
